// File: rtl/init_sequencer.sv
// Sequences the buffer-init loader over enabled buffers in id order; init_start lands 2 cycles after cfg_start or init_done.
// Stalls in WAIT until the loader's init_done; the optional watchdog (INIT_SEQ_TIMEOUT_EN) aborts a stuck WAIT.
module init_sequencer #(
  parameter int DDR_ADDR_WIDTH       = 32,
  parameter int DDR_BLOCK_SIZE_WIDTH = 8,
  parameter int BUFFER_ID_WIDTH      = 3,
  parameter int BUFFER_COUNT         = 4,
  parameter int TIMEOUT_WIDTH        = 16
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         cfg_start_i,
  input  logic [BUFFER_COUNT-1:0]                      cfg_enable_i,
  input  logic [BUFFER_COUNT*DDR_ADDR_WIDTH-1:0]       cfg_base_addr_i,
  input  logic [BUFFER_COUNT*DDR_BLOCK_SIZE_WIDTH-1:0] cfg_block_size_i,
  input  logic [TIMEOUT_WIDTH-1:0]                     cfg_timeout_i,
  output logic                                         init_start_o,
  output logic [BUFFER_ID_WIDTH-1:0]                   init_buffer_id_o,
  output logic [DDR_ADDR_WIDTH-1:0]                    init_base_addr_o,
  output logic [DDR_BLOCK_SIZE_WIDTH-1:0]              init_block_size_o,
  input  logic                                         init_done_i,
  output logic                                         busy_o,
  output logic                                         seq_done_o,
  output logic [BUFFER_COUNT-1:0]                      loaded_mask_o,
  output logic                                         seq_err_o
);

  localparam int IDX_W = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [BUFFER_COUNT-1:0]         mask_q, mask_d;
  logic                            err_q, err_d;
  logic                            latch_cfg;
  logic [BUFFER_COUNT-1:0]         en_q;
  logic [DDR_ADDR_WIDTH-1:0]       base_q [BUFFER_COUNT];
  logic [DDR_BLOCK_SIZE_WIDTH-1:0] size_q [BUFFER_COUNT];
  logic                            is_last;
  logic                            buf_go;
  logic                            wd_expired;
  logic                            active;

  assign is_last = (idx_q == LAST_IDX);
  assign buf_go  = en_q[idx_q] && (size_q[idx_q] != '0);

`ifdef INIT_SEQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d, wd_inc, timeout_q;

  // wd_inc counts the current WAIT cycle, so a timeout of N ends WAIT after N cycles.
  assign wd_inc     = wd_cnt_q + TIMEOUT_WIDTH'(1);
  assign wd_expired = (state_q == S_WAIT) && (timeout_q != '0) && (wd_inc == timeout_q);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (latch_cfg) begin
        timeout_q <= cfg_timeout_i;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout_i;
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    err_d     = err_q;
    latch_cfg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          state_d   = S_SCAN;
          latch_cfg = 1'b1;
          idx_d     = '0;
          mask_d    = '0;
          err_d     = 1'b0;
        end
      end
      S_SCAN: begin
        if (buf_go) begin
          state_d = S_ISSUE;
        end else if (is_last) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // A done coincident with ISSUE is dropped: the loader has not started yet.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (init_done_i) begin
          mask_d[idx_q] = 1'b1;
          if (is_last) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SCAN;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= '0;
      for (int i = 0; i < BUFFER_COUNT; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      if (latch_cfg) begin
        en_q <= cfg_enable_i;
        for (int i = 0; i < BUFFER_COUNT; i++) begin
          base_q[i] <= cfg_base_addr_i[i*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
          size_q[i] <= cfg_block_size_i[i*DDR_BLOCK_SIZE_WIDTH +: DDR_BLOCK_SIZE_WIDTH];
        end
      end
    end
  end

  assign active            = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign init_start_o      = (state_q == S_ISSUE);
  assign init_buffer_id_o  = active ? BUFFER_ID_WIDTH'(idx_q) : '0;
  assign init_base_addr_o  = active ? base_q[idx_q] : '0;
  assign init_block_size_o = active ? size_q[idx_q] : '0;
  assign busy_o            = (state_q != S_IDLE);
  assign seq_done_o        = (state_q == S_FINISH);
  assign loaded_mask_o     = mask_q;
  assign seq_err_o         = err_q;

endmodule
